mips_regfile_bypass: RTL and testbench

//   Next-generation MIPS register file: parametrised width/depth, two write ports
//   (A: ALU writeback, B: load writeback), optional same-cycle write->read bypass,
//   HI/LO pair for mult/div, and a load scoreboard that raises a stall on

---
 rtl/mips_regfile_bypass_if.sv | 53 +++++
 rtl/mips_regfile_bypass.sv | 126 ++++++++++++
 tb/tb_mips_regfile_bypass.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/mips_regfile_bypass_if.sv
// Register-file bus: decode read ports, writeback write ports, HI/LO and
// load-scoreboard signals, grouped so the core connects them as one bundle.
interface mips_regfile_bypass_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    // Decode-side read ports
    logic [ADDR_W-1:0] rr1;
    logic [ADDR_W-1:0] rr2;
    logic [DATA_W-1:0] rs;
    logic [DATA_W-1:0] rt;
    logic [DATA_W-1:0] v0;

    // Writeback port A (ALU) and port B (load return)
    logic              wren_a;
    logic [ADDR_W-1:0] wr_a;
    logic [DATA_W-1:0] wd_a;
    logic              wren_b;
    logic [ADDR_W-1:0] wr_b;
    logic [DATA_W-1:0] wd_b;

    // HI/LO pair for mult/div
    logic              hilo_wren;
    logic [DATA_W-1:0] hi_wd;
    logic [DATA_W-1:0] lo_wd;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    // Load scoreboard
    logic              ld_issue;
    logic [ADDR_W-1:0] ld_dst;
    logic              stall;

    // Pipeline side: drives addresses, writes and load issue; sees data and stall
    modport master (
        output rr1, rr2,
        output wren_a, wr_a, wd_a,
        output wren_b, wr_b, wd_b,
        output hilo_wren, hi_wd, lo_wd,
        output ld_issue, ld_dst,
        input  rs, rt, v0, hi, lo, stall
    );

    // Register file side
    modport slave (
        input  rr1, rr2,
        input  wren_a, wr_a, wd_a,
        input  wren_b, wr_b, wd_b,
        input  hilo_wren, hi_wd, lo_wd,
        input  ld_issue, ld_dst,
        output rs, rt, v0, hi, lo, stall
    );
endinterface

// File: rtl/mips_regfile_bypass.sv
// MIPS register file with two write ports (A = ALU, B = load return),
// optional same-cycle write->read bypass, HI/LO pair and a load scoreboard
// that flags read-after-load hazards to decode.
module mips_regfile_bypass #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter bit BYPASS = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    mips_regfile_bypass_if.slave  rf
);
    localparam int NREGS = 2 ** ADDR_W;

    // Architectural state
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic [NREGS-1:0]  busy_q;
    logic [NREGS-1:0]  busy_d;

    // Per-register write selects; register 0 is never selected so it stays 0
    logic [NREGS-1:0]  sel_a;
    logic [NREGS-1:0]  sel_b;

    // Read-port results
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              clr1;
    logic              clr2;
    logic              hazard1;
    logic              hazard2;

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
            if (gi == 0) begin : g_zero
                assign sel_a[gi]  = 1'b0;
                assign sel_b[gi]  = 1'b0;
                assign busy_d[gi] = 1'b0;
            end else begin : g_nonzero
                assign sel_a[gi] = rf.wren_a && (rf.wr_a == IDX);
                assign sel_b[gi] = rf.wren_b && (rf.wr_b == IDX);
                // A newly issued load re-marks the register busy even when an
                // older load to the same register returns in the same cycle.
                assign busy_d[gi] = (rf.ld_issue && (rf.ld_dst == IDX)) ||
                                    (busy_q[gi] && !sel_b[gi]);
            end
        end
    endgenerate

    // Register array update; port A wins an address conflict (younger instruction)
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREGS; i++) begin
            if (rst) begin
                regs_q[i] <= '0;
            end else if (sel_a[i]) begin
                regs_q[i] <= rf.wd_a;
            end else if (sel_b[i]) begin
                regs_q[i] <= rf.wd_b;
            end
        end
    end

    // HI/LO are written as a pair
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (rf.hilo_wren) begin
            hi_q <= rf.hi_wd;
            lo_q <= rf.lo_wd;
        end
    end

    // Scoreboard of registers awaiting load data
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Read port 1: r0 is hard zero, then bypass (A before B), then array
    always_comb begin
        rs_data = regs_q[rf.rr1];
        if (rf.rr1 == '0) begin
            rs_data = '0;
        end else if (BYPASS && rf.wren_a && (rf.wr_a == rf.rr1)) begin
            rs_data = rf.wd_a;
        end else if (BYPASS && rf.wren_b && (rf.wr_b == rf.rr1)) begin
            rs_data = rf.wd_b;
        end
    end

    // Read port 2: same priority as port 1
    always_comb begin
        rt_data = regs_q[rf.rr2];
        if (rf.rr2 == '0) begin
            rt_data = '0;
        end else if (BYPASS && rf.wren_a && (rf.wr_a == rf.rr2)) begin
            rt_data = rf.wd_a;
        end else if (BYPASS && rf.wren_b && (rf.wr_b == rf.rr2)) begin
            rt_data = rf.wd_b;
        end
    end

    // Hazard detect: a returning load clears its hazard this cycle only when
    // the data can actually be forwarded to the reader
    always_comb begin
        clr1    = BYPASS && rf.wren_b && (rf.wr_b == rf.rr1);
        clr2    = BYPASS && rf.wren_b && (rf.wr_b == rf.rr2);
        hazard1 = (rf.rr1 != '0) && busy_q[rf.rr1] && !clr1;
        hazard2 = (rf.rr2 != '0) && busy_q[rf.rr2] && !clr2;
    end

    assign rf.rs    = rs_data;
    assign rf.rt    = rt_data;
    assign rf.v0    = regs_q[2];
    assign rf.hi    = hi_q;
    assign rf.lo    = lo_q;
    assign rf.stall = hazard1 || hazard2;

endmodule

// File: tb/tb_mips_regfile_bypass.sv
// Bench for mips_regfile_bypass: runs the same stimulus into a BYPASS=1 and a
// BYPASS=0 instance and compares both against a behavioural model.
module tb_mips_regfile_bypass;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic clk;
    logic rst;

    int checks;
    int errors;
    bit model_ok;

    // Stimulus variables, copied into both interfaces by apply()
    logic [AW-1:0] rr1, rr2, wr_a, wr_b, ld_dst;
    logic [DW-1:0] wd_a, wd_b, hi_wd, lo_wd;
    logic          wren_a, wren_b, hilo_wren, ld_issue;

    // Behavioural model state
    logic [DW-1:0] m_reg [NR];
    bit            m_busy [NR];
    logic [DW-1:0] m_hi, m_lo;

    mips_regfile_bypass_if #(.DATA_W(DW), .ADDR_W(AW)) if1 ();
    mips_regfile_bypass_if #(.DATA_W(DW), .ADDR_W(AW)) if0 ();

    mips_regfile_bypass #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1'b1)) dut_byp (
        .clk (clk),
        .rst (rst),
        .rf  (if1.slave)
    );

    mips_regfile_bypass #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1'b0)) dut_nobyp (
        .clk (clk),
        .rst (rst),
        .rf  (if0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0; rr1 = '0; rr2 = '0;
        wren_a = 1'b0; wr_a = '0; wd_a = '0;
        wren_b = 1'b0; wr_b = '0; wd_b = '0;
        hilo_wren = 1'b0; hi_wd = '0; lo_wd = '0;
        ld_issue = 1'b0; ld_dst = '0;
    endtask

    task automatic apply();
        if1.rr1 = rr1; if1.rr2 = rr2;
        if1.wren_a = wren_a; if1.wr_a = wr_a; if1.wd_a = wd_a;
        if1.wren_b = wren_b; if1.wr_b = wr_b; if1.wd_b = wd_b;
        if1.hilo_wren = hilo_wren; if1.hi_wd = hi_wd; if1.lo_wd = lo_wd;
        if1.ld_issue = ld_issue; if1.ld_dst = ld_dst;
        if0.rr1 = rr1; if0.rr2 = rr2;
        if0.wren_a = wren_a; if0.wr_a = wr_a; if0.wd_a = wd_a;
        if0.wren_b = wren_b; if0.wr_b = wr_b; if0.wd_b = wd_b;
        if0.hilo_wren = hilo_wren; if0.hi_wd = hi_wd; if0.lo_wd = lo_wd;
        if0.ld_issue = ld_issue; if0.ld_dst = ld_dst;
    endtask

    // What a reader sees at address a, with or without forwarding
    function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return '0;
        if (byp && wren_a && wr_a == a) return wd_a;
        if (byp && wren_b && wr_b == a) return wd_b;
        return m_reg[a];
    endfunction

    function automatic bit exp_hazard(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return 1'b0;
        if (!m_busy[a]) return 1'b0;
        return !(byp && wren_b && wr_b == a);
    endfunction

    // Drive inputs, let them settle, compare every output of both instances
    task automatic settle();
        apply();
        #1;
        if (model_ok) begin
            check_val("rs_byp",     if1.rs, exp_read(rr1, 1'b1));
            check_val("rt_byp",     if1.rt, exp_read(rr2, 1'b1));
            check_val("rs_nobyp",   if0.rs, exp_read(rr1, 1'b0));
            check_val("rt_nobyp",   if0.rt, exp_read(rr2, 1'b0));
            check_val("v0_byp",     if1.v0, m_reg[2]);
            check_val("v0_nobyp",   if0.v0, m_reg[2]);
            check_val("hi_byp",     if1.hi, m_hi);
            check_val("lo_byp",     if1.lo, m_lo);
            check_val("hi_nobyp",   if0.hi, m_hi);
            check_val("lo_nobyp",   if0.lo, m_lo);
            check_val("stall_byp",  {31'd0, if1.stall},
                      {31'd0, exp_hazard(rr1, 1'b1) | exp_hazard(rr2, 1'b1)});
            check_val("stall_nobyp", {31'd0, if0.stall},
                      {31'd0, exp_hazard(rr1, 1'b0) | exp_hazard(rr2, 1'b0)});
        end
        $display("cyc rst=%0d rr1=%0d rr2=%0d A=%0d:%0d/%08h B=%0d:%0d/%08h ld=%0d:%0d rs=%08h rt=%08h stall=%0d/%0d",
                 rst, rr1, rr2, wren_a, wr_a, wd_a, wren_b, wr_b, wd_b, ld_issue, ld_dst,
                 if1.rs, if1.rt, if1.stall, if0.stall);
    endtask

    // Clock edge: advance the model with the inputs that were applied
    task automatic clock();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < NR; i++) begin
                m_reg[i] = '0;
                m_busy[i] = 1'b0;
            end
            m_hi = '0;
            m_lo = '0;
            model_ok = 1'b1;
        end else begin
            if (wren_b && wr_b != 0) m_reg[wr_b] = wd_b;
            if (wren_a && wr_a != 0) m_reg[wr_a] = wd_a;
            if (hilo_wren) begin
                m_hi = hi_wd;
                m_lo = lo_wd;
            end
            if (wren_b) m_busy[wr_b] = 1'b0;
            if (ld_issue && ld_dst != 0) m_busy[ld_dst] = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic step();
        settle();
        clock();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_ok = 1'b0;
        idle();
        @(negedge clk);

        // Reset, write r5, reset again: r5 reads 0
        rst = 1'b1; step();
        idle(); wren_a = 1'b1; wr_a = 5'd5; wd_a = 32'hDEADBEEF; step();
        idle(); rst = 1'b1; step();
        idle(); rr1 = 5'd5; settle();
        check_val("rst_rs", if1.rs, 32'h0);
        check_val("rst_hi", if1.hi, 32'h0);
        check_val("rst_stall", {31'd0, if1.stall}, 32'h0);
        clock();

        // r0 ignores writes and load issue
        idle(); wren_a = 1'b1; wr_a = 5'd0; wd_a = 32'h1234; ld_issue = 1'b1; ld_dst = 5'd0; step();
        idle(); rr1 = 5'd0; settle();
        check_val("r0_rs", if1.rs, 32'h0);
        check_val("r0_stall", {31'd0, if1.stall}, 32'h0);
        clock();

        // Bypass vs. no bypass
        idle(); wren_a = 1'b1; wr_a = 5'd7; wd_a = 32'h11; step();
        idle(); wren_a = 1'b1; wr_a = 5'd7; wd_a = 32'h55; rr1 = 5'd7; settle();
        check_val("byp_same", if1.rs, 32'h55);
        check_val("nobyp_old", if0.rs, 32'h11);
        clock();
        idle(); rr1 = 5'd7; settle();
        check_val("nobyp_next", if0.rs, 32'h55);
        clock();

        // A/B conflict: A wins, in bypass and in the array
        idle(); wren_a = 1'b1; wr_a = 5'd9; wd_a = 32'hA; wren_b = 1'b1; wr_b = 5'd9; wd_b = 32'hB;
        rr1 = 5'd9; settle();
        check_val("conf_byp", if1.rs, 32'hA);
        clock();
        idle(); rr1 = 5'd9; settle();
        check_val("conf_arr", if0.rs, 32'hA);
        clock();

        // Scoreboard
        idle(); ld_issue = 1'b1; ld_dst = 5'd4; step();
        idle(); rr2 = 5'd4; settle();
        check_val("sb_busy", {31'd0, if1.stall}, 32'h1);
        clock();
        idle(); rr2 = 5'd4; wren_b = 1'b1; wr_b = 5'd4; wd_b = 32'h77; settle();
        check_val("sb_clr_stall", {31'd0, if1.stall}, 32'h0);
        check_val("sb_clr_rt", if1.rt, 32'h77);
        check_val("sb_nobyp_stall", {31'd0, if0.stall}, 32'h1);
        clock();
        idle(); ld_issue = 1'b1; ld_dst = 5'd4; step();
        idle(); ld_issue = 1'b1; ld_dst = 5'd4; wren_b = 1'b1; wr_b = 5'd4; wd_b = 32'h88; step();
        idle(); rr2 = 5'd4; settle();
        check_val("sb_set_wins", {31'd0, if1.stall}, 32'h1);
        clock();

        // HI/LO and v0
        idle(); hilo_wren = 1'b1; hi_wd = 32'd1; lo_wd = 32'd2; wren_a = 1'b1; wr_a = 5'd2; wd_a = 32'd3; step();
        idle(); settle();
        check_val("hilo_hi", if1.hi, 32'd1);
        check_val("hilo_lo", if1.lo, 32'd2);
        check_val("v0_tap", if1.v0, 32'd3);
        clock();

        // Randomized traffic; narrow addresses half the time to provoke hazards
        for (int n = 0; n < 600; n++) begin
            bit narrow;
            idle();
            narrow    = ($urandom_range(0, 1) == 1);
            rst       = ($urandom_range(0, 63) == 0);
            rr1       = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
            rr2       = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
            wren_a    = ($urandom_range(0, 2) == 0);
            wr_a      = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
            wd_a      = $urandom;
            wren_b    = ($urandom_range(0, 2) == 0);
            wr_b      = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
            wd_b      = $urandom;
            hilo_wren = ($urandom_range(0, 3) == 0);
            hi_wd     = $urandom;
            lo_wd     = $urandom;
            ld_issue  = ($urandom_range(0, 2) == 0);
            ld_dst    = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
